// File: rtl/uart_loopback_fifo.sv
// UART loopback with per-byte transform, FIFO buffering, TX hold and drop accounting.
// uart_rx and uart_tx are the serial endpoints; uart_loopback_fifo is the top.

module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_Clk,
    input  logic       rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          dv_q, dv_d;

    always_comb begin
        sync_d    = {sync_q[0], i_Rx_Serial};
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_d     = bit_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;
        case (state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                bit_d     = '0;
                if (!sync_q[1]) state_d = RX_START;
            end
            RX_START: if (clk_cnt_q == HALF) begin
                clk_cnt_d = '0;
                state_d   = sync_q[1] ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (clk_cnt_q == FULL) begin
                clk_cnt_d     = '0;
                byte_d[bit_q] = sync_q[1];
                if (bit_q == 3'd7) state_d = RX_STOP;
                else               bit_d   = bit_q + 1'b1;
            end
            RX_STOP: if (clk_cnt_q == FULL) begin
                dv_d    = 1'b1;
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            sync_q    <= '1;
            clk_cnt_q <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            clk_cnt_q <= clk_cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
        end
    end

    assign o_Rx_DV   = dv_q;
    assign o_Rx_Byte = byte_q;
endmodule

// Deliberately unreset: a frame in flight keeps running through a top-level
// reset and is hidden by the top's output mask until it finishes.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_Clk,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t     state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          serial_q, serial_d, active_q, active_d, done_q, done_d;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;
        case (state_q)
            TX_IDLE: begin
                serial_d  = 1'b1;
                clk_cnt_d = '0;
                bit_d     = '0;
                if (i_Tx_DV) begin
                    shift_d  = i_Tx_Byte;
                    active_d = 1'b1;
                    serial_d = 1'b0;
                    state_d  = TX_START;
                end
            end
            TX_START: if (clk_cnt_q == FULL) begin
                clk_cnt_d = '0;
                serial_d  = shift_q[0];
                state_d   = TX_DATA;
            end
            TX_DATA: if (clk_cnt_q == FULL) begin
                clk_cnt_d = '0;
                if (bit_q == 3'd7) begin
                    serial_d = 1'b1;
                    state_d  = TX_STOP;
                end else begin
                    bit_d    = bit_q + 1'b1;
                    shift_d  = shift_q >> 1;
                    serial_d = shift_q[1];
                end
            end
            TX_STOP: if (clk_cnt_q == FULL) begin
                active_d = 1'b0;
                done_d   = 1'b1;
                state_d  = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        state_q   <= state_d;
        clk_cnt_q <= clk_cnt_d;
        bit_q     <= bit_d;
        shift_q   <= shift_d;
        serial_q  <= serial_d;
        active_q  <= active_d;
        done_q    <= done_d;
    end

    assign o_Tx_Active = active_q;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Done   = done_q;
endmodule

module uart_loopback_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 16
) (
    input  logic                          i_Clk,
    input  logic                          rst,
    input  logic                          i_UART_RX,
    output logic                          o_UART_TX,
    input  logic [1:0]                    i_Mode,
    input  logic [7:0]                    i_Key,
    input  logic                          i_Tx_Hold,
    input  logic                          i_Clear_Status,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Overflow,
    output logic [CNT_W-1:0]              o_Drop_Count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic             rx_dv, tx_active, tx_serial, tx_done;
    logic [7:0]       rx_byte;
    logic             xf_dv_q, xf_dv_d;
    logic [7:0]       xf_byte_q, xf_byte_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             tx_dv_q, tx_dv_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             mask_q, mask_d;
    logic             push, pop, drop;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_Clk(i_Clk), .rst_n(rst), .i_Rx_Serial(i_UART_RX),
        .o_Rx_DV(rx_dv), .o_Rx_Byte(rx_byte)
    );

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .i_Clk(i_Clk), .i_Tx_DV(tx_dv_q), .i_Tx_Byte(tx_byte_q),
        .o_Tx_Active(tx_active), .o_Tx_Serial(tx_serial), .o_Tx_Done(tx_done)
    );

    always_comb begin
        xf_dv_d   = rx_dv;
        xf_byte_d = xf_byte_q;
        if (rx_dv) begin
            case (i_Mode)
                2'b00:   xf_byte_d = rx_byte;
                2'b01:   xf_byte_d = ~rx_byte;
                2'b10:   xf_byte_d = rx_byte ^ i_Key;
                default: xf_byte_d = rx_byte + i_Key;
            endcase
        end
    end

    // A push into a full FIFO is still accepted when the scheduler pops the same cycle.
    always_comb begin
        pop  = (state_q == S_IDLE) && (count_q != '0) && !i_Tx_Hold && !tx_active && !mask_q;
        push = xf_dv_q && ((count_q != DEPTH_C) || pop);
        drop = xf_dv_q && !push;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (i_Clear_Status) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = i_Clear_Status ? CNT_W'(1) : ((&drop_q) ? drop_q : drop_q + 1'b1);
        end

        mask_d    = mask_q && tx_active;
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        case (state_q)
            S_IDLE: if (pop) begin
                tx_byte_d = mem_q[rd_ptr_q];
                tx_dv_d   = 1'b1;
                state_d   = S_SEND;
            end
            S_SEND:      state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (tx_done) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (push) mem_q[wr_ptr_q] <= xf_byte_q;
    end

    always_ff @(posedge i_Clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            xf_dv_q   <= 1'b0;
            xf_byte_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            mask_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            xf_dv_q   <= xf_dv_d;
            xf_byte_q <= xf_byte_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            mask_q    <= mask_d;
        end
    end

    // mask_q is set asynchronously by reset, so the line is forced high during reset too.
    assign o_UART_TX    = (tx_active && !mask_q) ? tx_serial : 1'b1;
    assign o_Fifo_Count = count_q;
    assign o_Overflow   = ovf_q;
    assign o_Drop_Count = drop_q;
endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Bench for uart_loopback_fifo: a full-size instance for the echo/latency case and a
// small fast instance (depth 4, 2-bit drop counter) for FIFO, status and reset corners.
`timescale 1ns/1ps

module tb_uart_loopback_fifo;
    localparam int BIT_A = 434;
    localparam int BIT_B = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_a, rx_b, tx_a, tx_b;
    logic [1:0]  mode;
    logic [7:0]  key;
    logic        hold, clr;
    logic [4:0]  cnt_a;
    logic [2:0]  cnt_b;
    logic        ovf_a, ovf_b;
    logic [15:0] drop_a;
    logic [1:0]  drop_b;

    int total = 0;
    int bad = 0;
    int rst_pulses = 0;
    int glitches, n;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    typedef struct {
        logic [1:0] mode;
        logic [7:0] key;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_loopback_fifo #(.CLKS_PER_BIT(BIT_A), .FIFO_DEPTH(16), .CNT_W(16)) dut_a (
        .i_Clk(clk), .rst(rst), .i_UART_RX(rx_a), .o_UART_TX(tx_a),
        .i_Mode(mode), .i_Key(key), .i_Tx_Hold(hold), .i_Clear_Status(clr),
        .o_Fifo_Count(cnt_a), .o_Overflow(ovf_a), .o_Drop_Count(drop_a)
    );

    uart_loopback_fifo #(.CLKS_PER_BIT(BIT_B), .FIFO_DEPTH(4), .CNT_W(2)) dut_b (
        .i_Clk(clk), .rst(rst), .i_UART_RX(rx_b), .o_UART_TX(tx_b),
        .i_Mode(mode), .i_Key(key), .i_Tx_Hold(hold), .i_Clear_Status(clr),
        .o_Fifo_Count(cnt_b), .o_Overflow(ovf_b), .o_Drop_Count(drop_b)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic line_of(input int inst);
        return (inst != 0) ? tx_b : tx_a;
    endfunction

    task automatic send(input int inst, input logic [7:0] b);
        int bp = (inst != 0) ? BIT_B : BIT_A;
        logic [9:0] fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (inst != 0) rx_b = fr[i];
            else           rx_a = fr[i];
            repeat (bp) @(negedge clk);
        end
    endtask

    task automatic drain(input int inst, input int nbits, input string name);
        int bp = (inst != 0) ? BIT_B : BIT_A;
        int k = 0;
        while (((inst != 0) ? q_b.size() : q_a.size()) != 0 && k < nbits * bp) begin
            @(negedge clk);
            k++;
        end
        check(name, (inst != 0) ? q_b.size() : q_a.size(), 0);
    endtask

    // Frames overlapped by a reset pulse are discarded rather than scored.
    task automatic monitor(input int inst);
        int bp = (inst != 0) ? BIT_B : BIT_A;
        int r0;
        logic [7:0] got, e;
        forever begin
            @(negedge clk);
            if (line_of(inst) == 1'b0) begin
                r0 = rst_pulses;
                repeat (bp / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (bp) @(negedge clk);
                    got[i] = line_of(inst);
                end
                repeat (bp) @(negedge clk);
                if (r0 == rst_pulses) begin
                    if (((inst != 0) ? q_b.size() : q_a.size()) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_tx%0d: got %02h expected none", inst, got);
                    end else begin
                        e = (inst != 0) ? q_b.pop_front() : q_a.pop_front();
                        check($sformatf("echo%0d", inst), 32'(got), 32'(e));
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b01, 8'h00, 8'h55, 8'hAA};
        vecs[1] = '{2'b10, 8'hFF, 8'h0F, 8'hF0};
        vecs[2] = '{2'b11, 8'h10, 8'hF8, 8'h08};
        vecs[3] = '{2'b00, 8'h00, 8'hA5, 8'hA5};
        vecs[4] = '{2'b11, 8'h80, 8'h80, 8'h00};
        vecs[5] = '{2'b10, 8'h3C, 8'hC3, 8'hFF};

        rst = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
        mode = 2'b00; key = 8'h00; hold = 1'b0; clr = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx_a", 32'(tx_a), 1);
        check("rst_tx_b", 32'(tx_b), 1);
        check("rst_cnt_a", 32'(cnt_a), 0);
        check("rst_cnt_b", 32'(cnt_b), 0);
        check("rst_ovf_a", 32'(ovf_a), 0);
        check("rst_ovf_b", 32'(ovf_b), 0);
        check("rst_drop_a", 32'(drop_a), 0);
        check("rst_drop_b", 32'(drop_b), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Pass-through echo at full bit period, with rx_dv -> tx_dv latency.
        q_a.push_back(8'h5A);
        fork
            send(0, 8'h5A);
            begin
                int w = 0;
                int k = 0;
                while (!dut_a.rx_dv && w < 12 * BIT_A) begin @(negedge clk); w++; end
                while (!dut_a.tx_dv_q && k < 10) begin @(negedge clk); k++; end
                check("latency", k, 3);
            end
        join
        drain(0, 15, "drain_a");
        check("cnt_a_empty", 32'(cnt_a), 0);

        // Transform table.
        for (int v = 0; v < 6; v++) begin
            mode = vecs[v].mode;
            key  = vecs[v].key;
            q_b.push_back(vecs[v].dout);
            send(1, vecs[v].din);
            drain(1, 15, $sformatf("drain_vec%0d", v));
        end
        mode = 2'b00; key = 8'h00;
        repeat (2 * BIT_B) @(negedge clk);
        check("cnt_b_after_vecs", 32'(cnt_b), 0);

        // Hold with overflow: six bytes into a depth-4 FIFO.
        hold = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) q_b.push_back(8'(i));
            send(1, 8'(i));
        end
        repeat (4) @(negedge clk);
        check("hold_cnt", 32'(cnt_b), 4);
        check("hold_ovf", 32'(ovf_b), 1);
        check("hold_drop", 32'(drop_b), 2);
        hold = 1'b0;
        drain(1, 60, "drain_hold");
        repeat (2 * BIT_B) @(negedge clk);
        check("hold_cnt_empty", 32'(cnt_b), 0);

        // Clear, then saturate the 2-bit drop counter.
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        check("clr_ovf", 32'(ovf_b), 0);
        check("clr_drop", 32'(drop_b), 0);
        hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 4) q_b.push_back(8'(8'h10 + i));
            send(1, 8'(8'h10 + i));
        end
        repeat (4) @(negedge clk);
        check("sat_drop", 32'(drop_b), 3);
        check("sat_ovf", 32'(ovf_b), 1);
        check("sat_cnt", 32'(cnt_b), 4);

        // Clear coinciding with a drop: the drop wins.
        fork
            send(1, 8'h77);
            begin
                int w = 0;
                while (!dut_b.xf_dv_q && w < 20 * BIT_B) begin @(negedge clk); w++; end
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
            end
        join
        check("clrdrop_ovf", 32'(ovf_b), 1);
        check("clrdrop_drop", 32'(drop_b), 1);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        check("clr2_drop", 32'(drop_b), 0);

        // Write into a full FIFO in the same cycle as a pop.
        q_b.push_back(8'h99);
        fork
            send(1, 8'h99);
            begin
                int w = 0;
                while (!dut_b.xf_dv_q && w < 20 * BIT_B) begin @(negedge clk); w++; end
                hold = 1'b0;
                @(negedge clk);
                check("pushpop_cnt", 32'(cnt_b), 4);
                check("pushpop_ovf", 32'(ovf_b), 0);
                check("pushpop_drop", 32'(drop_b), 0);
            end
        join
        drain(1, 80, "drain_pushpop");
        repeat (2 * BIT_B) @(negedge clk);
        check("pushpop_cnt_empty", 32'(cnt_b), 0);

        // Reset in the middle of the 0xC3 frame with a loaded FIFO and a drop recorded.
        hold = 1'b1;
        send(1, 8'hC3);
        for (int i = 0; i < 4; i++) send(1, 8'(8'h21 + i));
        repeat (4) @(negedge clk);
        hold = 1'b0;
        n = 0;
        while (tx_b !== 1'b0 && n < 4 * BIT_B) begin @(negedge clk); n++; end
        repeat (3 * BIT_B) @(negedge clk);
        rst_pulses++;
        rst = 1'b0;
        #1;
        check("rst_mid_tx", 32'(tx_b), 1);
        repeat (2) @(negedge clk);
        check("rst_mid_cnt", 32'(cnt_b), 0);
        check("rst_mid_ovf", 32'(ovf_b), 0);
        check("rst_mid_drop", 32'(drop_b), 0);
        rst = 1'b1;
        glitches = 0;
        n = 0;
        while (dut_b.tx_active && n < 12 * BIT_B) begin
            @(negedge clk);
            n++;
            if (tx_b !== 1'b1) glitches++;
        end
        check("masked_after_rst", glitches, 0);
        check("trunc_frame_ends", 32'(dut_b.tx_active), 0);
        q_b.push_back(8'h3C);
        send(1, 8'h3C);
        drain(1, 15, "drain_after_rst");
        repeat (2 * BIT_B) @(negedge clk);
        check("final_cnt", 32'(cnt_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
